// File: rtl/riscv_pkg.sv
// riscv_pkg -- definitions shared by the instruction fetch front end.
//   ILEN              : instruction word width
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   FQ_DEPTH_DEFAULT  : default number of fetch queue entries
//   fetch_entry_t     : one fetch queue entry {pc, instr}
//   align_word()      : clears the byte-offset bits of an address
package riscv_pkg;

    localparam int          ILEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FQ_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small FIFO holding fetched {pc, instr} entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, data  : write data at the tail
//   pop         : remove the head entry
//   flush       : empty the queue; overrides push and pop
//   head        : head entry, all-zero while the queue is empty
//   count       : current occupancy
// The caller guarantees push never targets a full queue and pop never
// targets an empty one.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array has no reset; the occupancy count alone decides
    // what is valid, and head is forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl -- instruction fetch controller for a 1-cycle synchronous
// instruction memory, feeding decode through a small fetch queue.
//   clk, rst_n           : clock, asynchronous active-low reset
//   fetch_en             : allow new fetches (in-flight word still lands)
//   imem_addr            : byte address presented to memory (the PC)
//   imem_word            : memory data for the address sampled last cycle
//   redirect_valid/_pc   : branch/jump redirect strobe and target
//   if_valid/if_ready    : decode handshake for the head entry
//   if_instr/if_pc       : head entry contents
//   fetch_err            : one-cycle pulse after a misaligned redirect
//   fetch_count          : number of accepted entries (wraps)
module instr_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_word,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic [CW:0]   occ_next;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          pop;
    logic          push;
    logic          issue;

    // Space is reserved for the word still in flight, so an issue is only
    // allowed when the queue (after this cycle's dequeue) plus the in-flight
    // word leaves room. This is what makes a push into a full queue impossible.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pop      = 1'b0;
        push     = 1'b0;
        issue    = 1'b0;
        occ_next = '0;

        pop      = (count != '0) && if_ready;
        occ_next = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
        issue    = fetch_en && !redirect_valid && (occ_next < (CW + 1)'(FQ_DEPTH));
        // A redirect squashes the word returning this cycle.
        push     = inflight && !redirect_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            fetch_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            // The handshake completes even when a redirect flushes the queue.
            if (pop) fetch_count <= fetch_count + 32'd1;
            inflight <= issue;
            if (redirect_valid) begin
                pc <= align_word(redirect_pc);
            end else if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
        end
    end

    assign push_data = '{pc: inflight_pc, instr: imem_word};

    fetch_fifo #(.DEPTH(FQ_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .data  (push_data),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (count)
    );

    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
    import riscv_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_word;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_err;

    instr_fetch_ctrl #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_word      (imem_word),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_err      (fetch_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word at 4 is the addi from the spec, word at 12 is
    // all-zero, everything else is an address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd4)  return 32'h0010_0093;
        if (a == 32'd12) return 32'h0000_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) imem_word <= mem_word(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0]  m_pc;
    logic [31:0]  m_ipc;
    logic [31:0]  m_cnt;
    bit           m_inf;
    bit           m_err;
    fetch_entry_t m_q[$];

    task automatic model_reset();
        m_pc  = RPC;
        m_ipc = '0;
        m_cnt = '0;
        m_inf = 1'b0;
        m_err = 1'b0;
        m_q.delete();
    endtask

    // One clock edge of behaviour, using the inputs currently applied.
    task automatic model_step();
        int occ;
        bit iss;
        m_err = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (m_q.size() != 0 && if_ready) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 32'd1;
        end
        if (redirect_valid) begin
            m_q.delete();
            m_pc  = {redirect_pc[31:2], 2'b00};
            m_inf = 1'b0;
        end else begin
            occ = m_q.size() + (m_inf ? 1 : 0);
            iss = fetch_en && (occ < DEPTH);
            if (m_inf) m_q.push_back('{pc: m_ipc, instr: mem_word(m_ipc)});
            m_inf = iss;
            if (iss) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
    endtask

    function automatic logic [129:0] exp_vec();
        logic [31:0] p;
        logic [31:0] w;
        p = '0;
        w = '0;
        if (m_q.size() != 0) begin
            p = m_q[0].pc;
            w = m_q[0].instr;
        end
        return {m_q.size() != 0, p, w, m_err, m_cnt, m_pc};
    endfunction

    function automatic logic [129:0] obs_vec();
        return {if_valid, if_valid ? if_pc : 32'h0, if_valid ? if_instr : 32'h0,
                fetch_err, fetch_count, imem_addr};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        model_reset();
        #12;
        n_cmp++;
        if ({if_valid, fetch_err, fetch_count} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid=%b err=%b cnt=%h, want 0 0 0",
                     if_valid, fetch_err, fetch_count);
        end
        n_cmp++;
        if ({if_pc, if_instr, imem_addr} !== {32'h0, 32'h0, RPC}) begin
            n_err++;
            $display("FAIL reset_data: got pc=%h instr=%h addr=%h, want 0 0 %h",
                     if_pc, if_instr, imem_addr, RPC);
        end
        @(negedge clk);
        rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    endtask

    task automatic test_startup();
        logic [31:0] prev;
        bit          seen4;
        prev  = '0;
        seen4 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL startup_model c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                n_cmp++;
                if (if_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL startup_c1: got valid=%b want 0", if_valid);
                end
            end else if (c == 2) begin
                n_cmp++;
                if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin
                    n_err++;
                    $display("FAIL startup_c2: got valid=%b pc=%h want 1 0", if_valid, if_pc);
                end
            end else begin
                n_cmp++;
                if ({if_valid, if_pc} !== {1'b1, prev + 32'd4}) begin
                    n_err++;
                    $display("FAIL startup_seq c=%0d: got valid=%b pc=%h want 1 %h",
                             c, if_valid, if_pc, prev + 32'd4);
                end
            end
            if (if_valid && if_pc == 32'd4) begin
                seen4 = 1'b1;
                n_cmp++;
                if (if_instr !== 32'h0010_0093) begin
                    n_err++;
                    $display("FAIL startup_pc4: got instr=%h want 00100093", if_instr);
                end
            end
            prev = if_pc;
        end
        if (!seen4) begin
            n_cmp++;
            n_err++;
            $display("FAIL startup_pc4: entry pc=4 never presented");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold;
        logic [31:0] prev;
        hold = if_pc;
        if_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall_model c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            n_cmp++;
            if ({if_valid, if_pc} !== {1'b1, hold}) begin
                n_err++;
                $display("FAIL stall_hold c=%0d: got valid=%b pc=%h want 1 %h",
                         c, if_valid, if_pc, hold);
            end
        end
        if_ready = 1'b1;
        prev = hold;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL unstall_model c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            n_cmp++;
            if ({if_valid, if_pc} !== {1'b1, prev + 32'd4}) begin
                n_err++;
                $display("FAIL unstall_order c=%0d: got valid=%b pc=%h want 1 %h",
                         c, if_valid, if_pc, prev + 32'd4);
            end
            prev = if_pc;
        end
    endtask

    task automatic test_redirect_full();
        if_ready = 1'b0;
        for (int c = 0; c < 6 && m_q.size() < DEPTH; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rfull_fill c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'd72; if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            redirect_valid = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rfull_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (k < 2) begin
                if (if_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rfull_flush k=%0d: got valid=%b pc=%h want 0", k, if_valid, if_pc);
                end
            end else if ({if_valid, if_pc} !== {1'b1, 32'd72 + 32'(4 * (k - 2))}) begin
                n_err++;
                $display("FAIL rfull_target k=%0d: got valid=%b pc=%h want 1 %h",
                         k, if_valid, if_pc, 32'd72 + 32'(4 * (k - 2)));
            end
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'd74;
        for (int k = 0; k < 3; k++) begin
            tick();
            redirect_valid = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL misalign_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (fetch_err !== (k == 0)) begin
                n_err++;
                $display("FAIL misalign_err k=%0d: got %b want %b", k, fetch_err, k == 0);
            end
        end
        n_cmp++;
        if ({if_valid, if_pc} !== {1'b1, 32'd72}) begin
            n_err++;
            $display("FAIL misalign_pc: got valid=%b pc=%h want 1 00000048", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_handshake();
        logic [31:0] want;
        tick();
        want = m_cnt + 32'd1;
        redirect_valid = 1'b1; redirect_pc = 32'h100; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({if_valid, fetch_count} !== {1'b0, want}) begin
            n_err++;
            $display("FAIL redir_hs: got valid=%b cnt=%h want 0 %h", if_valid, fetch_count, want);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 32'($urandom_range(0, 63));
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_model c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        redirect_valid = 1'b0; fetch_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        if_ready = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
        for (int c = 0; c < 6 && m_q.size() < DEPTH; c++) tick();
        n_cmp++;
        if (if_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: got valid=%b want 1", if_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({if_valid, fetch_count, imem_addr} !== {1'b0, 32'h0, RPC}) begin
            n_err++;
            $display("FAIL rstmid_async: got valid=%b cnt=%h addr=%h want 0 0 %h",
                     if_valid, fetch_count, imem_addr, RPC);
        end
        @(negedge clk);
        rst_n = 1'b1; if_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rstmid_model c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 2) begin
                n_cmp++;
                if ({if_valid, if_pc} !== {1'b1, RPC}) begin
                    n_err++;
                    $display("FAIL rstmid_restart: got valid=%b pc=%h want 1 %h", if_valid, if_pc, RPC);
                end
            end
        end
    endtask

    task automatic test_count_wrap();
        @(negedge clk);
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        m_cnt = 32'hFFFF_FFFF;
        n_cmp++;
        if (fetch_count !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preload: got %h want ffffffff", fetch_count);
        end
        tick();
        n_cmp++;
        if (fetch_count !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_zero: got %h want 00000000", fetch_count);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL wrap_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_redirect_handshake();
        test_random();
        test_reset_mid();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

endmodule
